// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the board-level reset sequencer:
//   - seq_state_t : FSM state encoding (also the value driven on the
//                   sequencer's 3-bit state output)
//   - max4        : largest of four cycle parameters
//   - cnt_width_ok: elaboration-time check that a counter of a given width
//                   can count up to max_cycles-1
// ---------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CORE_RST  = 3'd2,
    ST_DP_RST    = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counters compare against (cycles-1) and the timeout counter saturates at
  // all-ones, so width bits are enough when max_cycles < 2**width.
  function automatic bit cnt_width_ok(input int unsigned width, input int unsigned max_cycles);
    if (width == 0) return 1'b0;
    if (width >= 32) return 1'b1;
    return max_cycles < (32'd1 << width);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_flops.sv
// ---------------------------------------------------------------------------
// sync_flops
// STAGES-deep single-bit synchroniser with asynchronous active-low clear.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low clear (chain loads RESET_VAL)
//   d     in  asynchronous input
//   q     out synchronised output (last flop of the chain)
// ---------------------------------------------------------------------------
module sync_flops #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Board-level reset / bring-up sequencer. Synchronises the pad reset release
// and the MMCM lock, waits for a stable lock, then releases the core reset
// and the AXIS datapath reset in order, each after a programmable hold.
// Lock loss after the first lock restarts the sequence from WAIT_LOCK; a
// software request in RUN re-runs the datapath reset only.
// Ports:
//   sys_clk         in  free-running sequencer clock
//   sys_reset_n     in  asynchronous active-low pad reset
//   mmcm_locked     in  asynchronous MMCM lock indication
//   soft_reset_req  in  single-cycle datapath reset request (sys_clk domain)
//   core_reset      out active-high core reset
//   dp_reset_n      out active-low datapath reset
//   ready           out high only in RUN
//   state           out current state encoding (seq_state_t)
//   lock_timeout    out sticky: lock not stable within LOCK_TIMEOUT_CYCLES
//   lock_loss_count out saturating count of lock losses
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned CORE_HOLD_CYCLES    = 200,
  parameter int unsigned DP_HOLD_CYCLES      = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_WIDTH           = 17
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       mmcm_locked,
  input  logic       soft_reset_req,
  output logic       core_reset,
  output logic       dp_reset_n,
  output logic       ready,
  output logic [2:0] state,
  output logic       lock_timeout,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MAX_CYCLES = max4(LOCK_STABLE_CYCLES, CORE_HOLD_CYCLES,
                                            DP_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES);

  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CORE_LAST = CNT_WIDTH'(CORE_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DP_LAST   = CNT_WIDTH'(DP_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);

  // Parameter sanity, evaluated at elaboration only.
  if (!cnt_width_ok(CNT_WIDTH, MAX_CYCLES)) begin : g_bad_cnt_width
    $error("reset_sequencer: CNT_WIDTH too small for the cycle parameters");
  end
  if (SYNC_STAGES < 2 || LOCK_STABLE_CYCLES < 1 || CORE_HOLD_CYCLES < 1 ||
      DP_HOLD_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("reset_sequencer: SYNC_STAGES must be >=2 and cycle counts >=1");
  end

  // -------------------------------------------------------------------------
  // Synchronisers
  // -------------------------------------------------------------------------
  logic rst_s;
  logic locked_s;

  // Constant 1 shifts in after reset release: rst_s rises SYNC_STAGES edges
  // after sys_reset_n deasserts, but drops immediately on assertion.
  sync_flops #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_rst_sync (
    .clk  (sys_clk),
    .rst_n(sys_reset_n),
    .d    (1'b1),
    .q    (rst_s)
  );

  // Lock is treated as absent until it has been observed through the chain.
  sync_flops #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk  (sys_clk),
    .rst_n(sys_reset_n),
    .d    (mmcm_locked),
    .q    (locked_s)
  );

  // -------------------------------------------------------------------------
  // State and counters
  // -------------------------------------------------------------------------
  seq_state_t           state_reg,        state_next;
  logic [CNT_WIDTH-1:0] cnt_reg,          cnt_next;
  logic [CNT_WIDTH-1:0] tmo_reg,          tmo_next;
  logic                 lock_timeout_reg, lock_timeout_next;
  logic [7:0]           llc_reg,          llc_next;
  logic                 core_reset_reg,   core_reset_next;
  logic                 dp_reset_n_reg,   dp_reset_n_next;
  logic                 ready_reg,        ready_next;
  logic                 lock_lost;

  // Lock loss only counts once the sequence has seen a stable lock.
  assign lock_lost = !locked_s &&
                     (state_reg == ST_CORE_RST || state_reg == ST_DP_RST ||
                      state_reg == ST_RUN);

  // State register (plus registered outputs)
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      tmo_reg          <= '0;
      lock_timeout_reg <= 1'b0;
      llc_reg          <= 8'd0;
      core_reset_reg   <= 1'b1;
      dp_reset_n_reg   <= 1'b0;
      ready_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      tmo_reg          <= tmo_next;
      lock_timeout_reg <= lock_timeout_next;
      llc_reg          <= llc_next;
      core_reset_reg   <= core_reset_next;
      dp_reset_n_reg   <= dp_reset_n_next;
      ready_reg        <= ready_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    tmo_next          = tmo_reg;
    lock_timeout_next = lock_timeout_reg;
    llc_next          = llc_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        tmo_next = '0;
        if (rst_s) state_next = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        if (tmo_reg != '1) tmo_next = tmo_reg + 1'b1;
        // Flag lands on the same edge the counter reaches its last value.
        if (tmo_next >= TMO_LAST) lock_timeout_next = 1'b1;

        if (!locked_s) begin
          cnt_next = '0;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next = ST_CORE_RST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_CORE_RST: begin
        if (cnt_reg == CORE_LAST) begin
          state_next = ST_DP_RST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DP_RST: begin
        if (cnt_reg == DP_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RUN: begin
        cnt_next = '0;
        if (soft_reset_req) state_next = ST_DP_RST;
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        tmo_next   = '0;
      end
    endcase

    // Overrides soft requests and hold completion. The timeout counter
    // restarts so lock_timeout measures the current lock attempt.
    if (lock_lost) begin
      state_next = ST_WAIT_LOCK;
      cnt_next   = '0;
      tmo_next   = '0;
      if (llc_reg != 8'hFF) llc_next = llc_reg + 8'd1;
    end
  end

  // Output decode from the next state so outputs change on the same edge as
  // the state register.
  always_comb begin
    core_reset_next = 1'b1;
    dp_reset_n_next = 1'b0;
    ready_next      = 1'b0;
    case (state_next)
      ST_DP_RST: begin
        core_reset_next = 1'b0;
      end
      ST_RUN: begin
        core_reset_next = 1'b0;
        dp_reset_n_next = 1'b1;
        ready_next      = 1'b1;
      end
      default: begin
        core_reset_next = 1'b1;
      end
    endcase
  end

  assign core_reset      = core_reset_reg;
  assign dp_reset_n      = dp_reset_n_reg;
  assign ready           = ready_reg;
  assign state           = state_reg;
  assign lock_timeout    = lock_timeout_reg;
  assign lock_loss_count = llc_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Self-checking bench for reset_sequencer with SYNC_STAGES=2, LOCK_STABLE=16,
// CORE_HOLD=8, DP_HOLD=4, LOCK_TIMEOUT=64. Edge numbers count sys_clk rising
// edges after sys_reset_n release (first edge = 1). Inputs are driven and
// outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       core_reset;
  logic       dp_reset_n;
  logic       ready;
  logic [2:0] state;
  logic       lock_timeout;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_no;
    logic [2:0] st;
    logic       core;
    logic       dpn;
    logic       rdy;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];
  vec_t sb_head;

  reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (16),
    .CORE_HOLD_CYCLES   (8),
    .DP_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(64),
    .CNT_WIDTH          (17)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_reset_n    (sys_reset_n),
    .mmcm_locked    (mmcm_locked),
    .soft_reset_req (soft_reset_req),
    .core_reset     (core_reset),
    .dp_reset_n     (dp_reset_n),
    .ready          (ready),
    .state          (state),
    .lock_timeout   (lock_timeout),
    .lock_loss_count(lock_loss_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (!sys_reset_n) edge_cnt <= 0;
    else              edge_cnt <= edge_cnt + 1;
  end

  // Scoreboard: pop the head record when its edge comes round.
  always @(negedge sys_clk) begin
    if (sys_reset_n && sb_q.size() > 0 && edge_cnt == sb_q[0].edge_no) begin
      sb_head = sb_q.pop_front();
      total++;
      if ({state, core_reset, dp_reset_n, ready} !==
          {sb_head.st, sb_head.core, sb_head.dpn, sb_head.rdy}) begin
        bad++;
        $display("FAIL sb_edge%0d: got st=%0d core=%b dpn=%b rdy=%b expected st=%0d core=%b dpn=%b rdy=%b",
                 sb_head.edge_no, state, core_reset, dp_reset_n, ready,
                 sb_head.st, sb_head.core, sb_head.dpn, sb_head.rdy);
      end else begin
        $display("ok   sb_edge%0d: st=%0d core=%b dpn=%b rdy=%b",
                 sb_head.edge_no, state, core_reset, dp_reset_n, ready);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  task automatic do_reset(input logic locked);
    @(negedge sys_clk);
    sys_reset_n    = 1'b0;
    mmcm_locked    = locked;
    soft_reset_req = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("reset_outputs", {21'd0, state, core_reset, dp_reset_n, ready, lock_timeout, lock_loss_count},
        {21'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    sys_reset_n = 1'b1;
  endtask

  task automatic goto_edge(input int k);
    int guard = 0;
    while (edge_cnt < k && guard < 10000) begin
      @(negedge sys_clk);
      guard++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    ok = (state === s);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_state: got %0d expected %0d within %0d cycles", state, s, budget);
    end
  endtask

  initial begin
    bit ok;

    // ---------------- 1. power-on, table-driven via scoreboard ------------
    vecs[0] = '{1,  3'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2,  3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3,  3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{18, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{19, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{26, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{27, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{30, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{31, 3'd4, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{35, 3'd4, 1'b0, 1'b1, 1'b1};

    do_reset(1'b1);
    for (int i = 0; i < 10; i++) sb_q.push_back(vecs[i]);
    goto_edge(40);
    chk("sb_drained", sb_q.size(), 0);

    // ---------------- 2. lock glitch in WAIT_LOCK -------------------------
    do_reset(1'b1);
    goto_edge(12);
    mmcm_locked = 1'b0;          // sampled at edge 13 only
    goto_edge(13);
    mmcm_locked = 1'b1;
    goto_edge(19);
    chk("glitch_state_e19", state, 1);
    goto_edge(30);
    chk("glitch_state_e30", state, 1);
    goto_edge(31);
    chk("glitch_state_e31", state, 2);
    chk("glitch_llc", lock_loss_count, 0);

    // ---------------- 3. lock never, then late lock -----------------------
    do_reset(1'b0);
    goto_edge(65);
    chk("tmo_e65", lock_timeout, 0);
    goto_edge(66);
    chk("tmo_e66", lock_timeout, 1);
    chk("tmo_state_e66", state, 1);
    goto_edge(70);
    mmcm_locked = 1'b1;
    goto_edge(88);
    chk("late_state_e88", state, 2);
    goto_edge(99);
    chk("late_ready_e99", ready, 0);
    goto_edge(100);
    chk("late_state_e100", state, 4);
    chk("late_ready_e100", ready, 1);
    chk("late_tmo_sticky", lock_timeout, 1);

    // ---------------- 4. lock loss in RUN ---------------------------------
    do_reset(1'b1);
    goto_edge(35);
    mmcm_locked = 1'b0;
    goto_edge(37);
    chk("loss_state_e37", state, 4);
    goto_edge(38);
    chk("loss_outs_e38", {state, core_reset, dp_reset_n, ready}, {3'd1, 1'b1, 1'b0, 1'b0});
    chk("loss_llc_e38", lock_loss_count, 1);
    chk("loss_tmo_e38", lock_timeout, 0);
    goto_edge(40);
    mmcm_locked = 1'b1;
    goto_edge(57);
    chk("relock_state_e57", state, 1);
    goto_edge(58);
    chk("relock_state_e58", state, 2);
    goto_edge(70);
    chk("relock_outs_e70", {state, core_reset, dp_reset_n, ready}, {3'd4, 1'b0, 1'b1, 1'b1});
    chk("relock_llc_e70", lock_loss_count, 1);
    // async assertion while in RUN: no clock edge between assert and sample
    #2 sys_reset_n = 1'b0;
    #1;
    chk("async_run_outs", {state, core_reset, dp_reset_n, ready, lock_loss_count},
        {3'd0, 1'b1, 1'b0, 1'b0, 8'd0});

    // ---------------- 5. soft reset ---------------------------------------
    do_reset(1'b1);
    goto_edge(33);
    soft_reset_req = 1'b1;       // sampled at edge 34
    goto_edge(34);
    soft_reset_req = 1'b0;
    chk("soft_outs_e34", {state, core_reset, dp_reset_n, ready}, {3'd3, 1'b0, 1'b0, 1'b0});
    goto_edge(37);
    chk("soft_dpn_e37", {core_reset, dp_reset_n}, {1'b0, 1'b0});
    goto_edge(38);
    chk("soft_outs_e38", {state, core_reset, dp_reset_n, ready}, {3'd4, 1'b0, 1'b1, 1'b1});
    goto_edge(40);
    soft_reset_req = 1'b1;       // edge 41 -> DP_RST
    goto_edge(41);
    soft_reset_req = 1'b0;
    goto_edge(42);
    soft_reset_req = 1'b1;       // edge 43, inside DP_RST: ignored
    goto_edge(43);
    soft_reset_req = 1'b0;
    goto_edge(44);
    chk("soft_dp_e44", state, 3);
    goto_edge(45);
    chk("soft_dp_ign_e45", state, 4);
    goto_edge(47);
    mmcm_locked = 1'b0;          // locked_s low seen by FSM at edge 50
    goto_edge(49);
    soft_reset_req = 1'b1;       // also at edge 50
    goto_edge(50);
    soft_reset_req = 1'b0;
    chk("soft_vs_loss_e50", {state, core_reset, dp_reset_n, ready}, {3'd1, 1'b1, 1'b0, 1'b0});
    chk("soft_vs_loss_llc", lock_loss_count, 1);

    // ---------------- 6. saturation and async reset in CORE_RST -----------
    do_reset(1'b1);
    for (int i = 1; i <= 256; i++) begin
      wait_state(3'd2, 200, ok);
      if (!ok) break;
      mmcm_locked = 1'b0;
      wait_state(3'd1, 20, ok);
      if (!ok) break;
      mmcm_locked = 1'b1;
      if (i == 1 || i == 128 || i == 255 || i == 256)
        chk($sformatf("llc_after_%0d", i), lock_loss_count, (i > 255) ? 255 : i);
    end
    wait_state(3'd2, 200, ok);
    #2 sys_reset_n = 1'b0;
    #1;
    chk("async_core_outs", {state, core_reset, dp_reset_n, ready, lock_timeout, lock_loss_count},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge sys_clk);
    sys_reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
